// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access for the MEM stage and the MEM/WB pipeline
// register. Big-endian byte/halfword/word loads and stores, sign or zero
// extension on loads, misalignment detection, and a stall that freezes the
// pipeline register and blocks stores.
module mem_wb_stage #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        STALL,
    input  logic [31:0] EX_MEM_aluResult_out,
    input  logic [31:0] EX_MEM_writeData_out,
    input  logic [4:0]  EX_MEM_rd_out,
    input  logic        EX_MEM_memRead_out,
    input  logic        EX_MEM_memWrite_out,
    input  logic        EX_MEM_memToReg_out,
    input  logic        EX_MEM_regWrite_out,
    input  logic [1:0]  EX_MEM_size_out,
    input  logic        EX_MEM_unsigned_out,
    output logic [31:0] MEM_WB_readData_out,
    output logic [31:0] MEM_WB_aluResult_out,
    output logic [4:0]  MEM_WB_rd_out,
    output logic        MEM_WB_regWrite_out,
    output logic        MEM_WB_memToReg_out,
    output logic        MEM_WB_misaligned_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Data memory; deliberately not reset so contents survive RST.
    logic [31:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            byte_off;
    logic [31:0]           rd_word;
    logic                  mis;
    logic                  is_load;
    logic                  store_en;
    logic [7:0]            lane8;
    logic [15:0]           lane16;
    logic [31:0]           load_data;
    logic [31:0]           wr_word;

    logic [31:0] read_data_d, read_data_q;
    logic [31:0] alu_result_d, alu_result_q;
    logic [4:0]  rd_d, rd_q;
    logic        reg_write_d, reg_write_q;
    logic        mem_to_reg_d, mem_to_reg_q;
    logic        misaligned_d, misaligned_q;

    // Address decode, alignment check and access qualification.
    always_comb begin
        word_idx = EX_MEM_aluResult_out[ADDR_WIDTH+1:2];
        byte_off = EX_MEM_aluResult_out[1:0];
        rd_word  = mem_q[word_idx];
        mis      = 1'b0;
        if (EX_MEM_memRead_out || EX_MEM_memWrite_out) begin
            if (EX_MEM_size_out == 2'b01)
                mis = byte_off[0];
            else if (EX_MEM_size_out[1])
                mis = (byte_off != 2'b00);
        end
        // A simultaneous read+write is handled as a store.
        is_load  = EX_MEM_memRead_out && !EX_MEM_memWrite_out && !mis;
        store_en = EX_MEM_memWrite_out && !mis && !STALL && !RST;
    end

    // Lane selection and extension for loads (offset 0 is the MSB lane).
    always_comb begin
        case (byte_off)
            2'd0:    lane8 = rd_word[31:24];
            2'd1:    lane8 = rd_word[23:16];
            2'd2:    lane8 = rd_word[15:8];
            default: lane8 = rd_word[7:0];
        endcase
        lane16 = byte_off[1] ? rd_word[15:0] : rd_word[31:16];
        case (EX_MEM_size_out)
            2'b00:   load_data = {{24{lane8[7] & ~EX_MEM_unsigned_out}}, lane8};
            2'b01:   load_data = {{16{lane16[15] & ~EX_MEM_unsigned_out}}, lane16};
            default: load_data = rd_word;
        endcase
    end

    // Merge store data into the addressed lanes of the current word.
    always_comb begin
        wr_word = rd_word;
        case (EX_MEM_size_out)
            2'b00: begin
                case (byte_off)
                    2'd0:    wr_word[31:24] = EX_MEM_writeData_out[7:0];
                    2'd1:    wr_word[23:16] = EX_MEM_writeData_out[7:0];
                    2'd2:    wr_word[15:8]  = EX_MEM_writeData_out[7:0];
                    default: wr_word[7:0]   = EX_MEM_writeData_out[7:0];
                endcase
            end
            2'b01: begin
                if (byte_off[1])
                    wr_word[15:0]  = EX_MEM_writeData_out[15:0];
                else
                    wr_word[31:16] = EX_MEM_writeData_out[15:0];
            end
            default: wr_word = EX_MEM_writeData_out;
        endcase
    end

    // Store commit; RST and STALL are already folded into store_en.
    always_ff @(posedge CLK) begin
        if (store_en)
            mem_q[word_idx] <= wr_word;
    end

    // Next MEM/WB register contents; a stall holds the current contents.
    always_comb begin
        read_data_d  = is_load ? load_data : 32'h0;
        alu_result_d = EX_MEM_aluResult_out;
        rd_d         = EX_MEM_rd_out;
        reg_write_d  = EX_MEM_regWrite_out &&
                       !(EX_MEM_memRead_out && !EX_MEM_memWrite_out && mis);
        mem_to_reg_d = EX_MEM_memToReg_out;
        misaligned_d = mis;
        if (STALL) begin
            read_data_d  = read_data_q;
            alu_result_d = alu_result_q;
            rd_d         = rd_q;
            reg_write_d  = reg_write_q;
            mem_to_reg_d = mem_to_reg_q;
            misaligned_d = misaligned_q;
        end
    end

    // MEM/WB pipeline register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            read_data_q  <= 32'h0;
            alu_result_q <= 32'h0;
            rd_q         <= 5'h0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign MEM_WB_readData_out   = read_data_q;
    assign MEM_WB_aluResult_out  = alu_result_q;
    assign MEM_WB_rd_out         = rd_q;
    assign MEM_WB_regWrite_out   = reg_write_q;
    assign MEM_WB_memToReg_out   = mem_to_reg_q;
    assign MEM_WB_misaligned_out = misaligned_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: drives one EX/MEM instruction per cycle and
// checks the MEM/WB register one time unit after each rising edge.
module tb_mem_wb_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        STALL;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] o_read_data;
    logic [31:0] o_alu;
    logic [4:0]  o_rd;
    logic        o_reg_write;
    logic        o_mem_to_reg;
    logic        o_mis;

    int n_tests = 0;
    int n_fail  = 0;

    mem_wb_stage #(.ADDR_WIDTH(8)) dut (
        .CLK                   (CLK),
        .RST                   (RST),
        .STALL                 (STALL),
        .EX_MEM_aluResult_out  (alu),
        .EX_MEM_writeData_out  (wdata),
        .EX_MEM_rd_out         (rd),
        .EX_MEM_memRead_out    (mem_read),
        .EX_MEM_memWrite_out   (mem_write),
        .EX_MEM_memToReg_out   (mem_to_reg),
        .EX_MEM_regWrite_out   (reg_write),
        .EX_MEM_size_out       (size),
        .EX_MEM_unsigned_out   (uns),
        .MEM_WB_readData_out   (o_read_data),
        .MEM_WB_aluResult_out  (o_alu),
        .MEM_WB_rd_out         (o_rd),
        .MEM_WB_regWrite_out   (o_reg_write),
        .MEM_WB_memToReg_out   (o_mem_to_reg),
        .MEM_WB_misaligned_out (o_mis)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Set up one EX/MEM instruction.
    task automatic op(input logic r, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d, input logic [4:0] dst,
                      input logic rw, input logic m2r);
        mem_read   = r;
        mem_write  = w;
        size       = sz;
        uns        = u;
        alu        = a;
        wdata      = d;
        rd         = dst;
        reg_write  = rw;
        mem_to_reg = m2r;
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        op(1'b0, 1'b1, 2'b10, 1'b0, a, d, 5'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic load(input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [4:0] dst);
        op(1'b1, 1'b0, sz, u, a, 32'h0, dst, 1'b1, 1'b1);
        tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdata"}, o_read_data, 32'h0);
        chk({tag, "_alu"}, o_alu, 32'h0);
        chk({tag, "_ctl"}, {24'h0, o_rd, o_reg_write, o_mem_to_reg, o_mis}, 32'h0);
    endtask

    initial begin
        RST   = 1'b1;
        STALL = 1'b0;
        op(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b1);

        // Reset with a pending store
        tick();
        chk_zero("reset1");
        tick();
        chk_zero("reset2");

        RST = 1'b0;
        sw(32'h0, 32'h1234_5678);
        chk("sw0_rdata", o_read_data, 32'h0);
        load(2'b10, 1'b0, 32'h0, 5'd3);
        chk("lw0_rdata", o_read_data, 32'h1234_5678);
        chk("lw0_rd", {27'h0, o_rd}, 32'd3);
        chk("lw0_ctl", {30'h0, o_reg_write, o_mem_to_reg}, 32'h3);

        // Store issued while RST is high must not land
        sw(32'h60, 32'hA5A5_A5A5);
        RST = 1'b1;
        op(1'b0, 1'b1, 2'b10, 1'b0, 32'h60, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0);
        tick();
        RST = 1'b0;
        load(2'b10, 1'b0, 32'h60, 5'd1);
        chk("rst_store_blocked", o_read_data, 32'hA5A5_A5A5);

        // Word store then load
        sw(32'h10, 32'hDEAD_BEEF);
        load(2'b10, 1'b0, 32'h10, 5'd8);
        chk("lw10_rdata", o_read_data, 32'hDEAD_BEEF);
        chk("lw10_rd", {27'h0, o_rd}, 32'd8);
        chk("lw10_regw", {31'h0, o_reg_write}, 32'h1);
        chk("lw10_alu", o_alu, 32'h10);

        // Non-memory instruction passes through with zero read data
        op(1'b0, 1'b0, 2'b10, 1'b0, 32'hCAFE_F00D, 32'h1111_1111, 5'd9, 1'b1, 1'b0);
        tick();
        chk("alu_rdata", o_read_data, 32'h0);
        chk("alu_alu", o_alu, 32'hCAFE_F00D);
        chk("alu_ctl", {24'h0, o_rd, o_reg_write, o_mem_to_reg, o_mis}, {24'h0, 5'd9, 3'b100});

        // Byte / halfword extension
        sw(32'h20, 32'h80F1_7F00);
        load(2'b00, 1'b0, 32'h20, 5'd2);
        chk("lb20", o_read_data, 32'hFFFF_FF80);
        load(2'b00, 1'b1, 32'h20, 5'd2);
        chk("lbu20", o_read_data, 32'h0000_0080);
        load(2'b00, 1'b0, 32'h21, 5'd2);
        chk("lb21", o_read_data, 32'hFFFF_FFF1);
        load(2'b00, 1'b0, 32'h22, 5'd2);
        chk("lb22", o_read_data, 32'h0000_007F);
        load(2'b00, 1'b0, 32'h23, 5'd2);
        chk("lb23", o_read_data, 32'h0000_0000);
        load(2'b01, 1'b0, 32'h22, 5'd2);
        chk("lh22", o_read_data, 32'h0000_7F00);
        load(2'b01, 1'b1, 32'h20, 5'd2);
        chk("lhu20", o_read_data, 32'h0000_80F1);
        load(2'b01, 1'b0, 32'h20, 5'd2);
        chk("lh20", o_read_data, 32'hFFFF_80F1);

        // Partial stores leave other lanes intact
        sw(32'h30, 32'h1122_3344);
        op(1'b0, 1'b1, 2'b00, 1'b0, 32'h31, 32'hFFFF_FFAA, 5'd0, 1'b0, 1'b0);
        tick();
        op(1'b0, 1'b1, 2'b01, 1'b0, 32'h32, 32'h1234_BBCC, 5'd0, 1'b0, 1'b0);
        tick();
        load(2'b10, 1'b0, 32'h30, 5'd4);
        chk("partial30", o_read_data, 32'h11AA_BBCC);

        // Misaligned accesses
        sw(32'h40, 32'h0102_0304);
        load(2'b10, 1'b0, 32'h41, 5'd4);
        chk("mis_lw_rdata", o_read_data, 32'h0);
        chk("mis_lw_flags", {30'h0, o_reg_write, o_mis}, 32'h1);
        op(1'b0, 1'b1, 2'b01, 1'b0, 32'h43, 32'h0000_FFFF, 5'd0, 1'b0, 1'b0);
        tick();
        chk("mis_sh_flag", {31'h0, o_mis}, 32'h1);
        load(2'b10, 1'b0, 32'h42, 5'd4);
        chk("mis_lw42_flag", {31'h0, o_mis}, 32'h1);
        load(2'b10, 1'b0, 32'h40, 5'd4);
        chk("mis_word40", o_read_data, 32'h0102_0304);
        chk("mis_clear", {31'h0, o_mis}, 32'h0);
        load(2'b00, 1'b1, 32'h43, 5'd4);
        chk("lbu43_aligned", {o_read_data[30:0], o_mis}, {31'h04, 1'b0});

        // Stall holds MEM/WB and blocks the store
        sw(32'h50, 32'h0000_0099);
        load(2'b10, 1'b0, 32'h50, 5'd7);
        chk("pre_stall", o_read_data, 32'h99);
        STALL = 1'b1;
        op(1'b0, 1'b1, 2'b10, 1'b0, 32'h50, 32'h0000_0005, 5'd0, 1'b0, 1'b0);
        tick();
        chk("stall_rdata", o_read_data, 32'h99);
        chk("stall_ctl", {24'h0, o_rd, o_reg_write, o_mem_to_reg, o_mis}, {24'h0, 5'd7, 3'b110});
        chk("stall_alu", o_alu, 32'h50);
        STALL = 1'b0;
        load(2'b10, 1'b0, 32'h50, 5'd7);
        chk("post_stall_lw", o_read_data, 32'h99);

        // Misaligned flag held through a stall
        load(2'b10, 1'b0, 32'h41, 5'd6);
        STALL = 1'b1;
        op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("stall_mis_hold", {31'h0, o_mis}, 32'h1);
        STALL = 1'b0;
        tick();
        chk("mis_release", {31'h0, o_mis}, 32'h0);

        // Address wraps modulo the memory depth
        sw(32'h400, 32'h0000_0077);
        load(2'b10, 1'b0, 32'h0, 5'd1);
        chk("wrap", o_read_data, 32'h77);

        // RST wins over STALL
        RST   = 1'b1;
        STALL = 1'b1;
        tick();
        chk_zero("rst_over_stall");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage of the five-stage MIPS pipeline: consumes the EX/MEM pipeline register (ALU result, store data, destination register, control bits), performs the data-memory load or store, and produces the registered MEM/WB pipeline register that feeds write-back. Supports byte, halfword and word accesses, big-endian, with sign or zero extension on loads, misalignment detection, and a pipeline stall input.

## Interface
- ADDR_WIDTH, 8: log2 of data-memory depth in 32-bit words (256 words default)
- CLK  in  1  pipeline clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- STALL  in  1  hold MEM/WB register and suppress store this cycle
- EX_MEM_aluResult_out  in  32  byte address for loads/stores; pass-through result otherwise
- EX_MEM_writeData_out  in  32  store data (rt value)
- EX_MEM_rd_out  in  5  destination register number
- EX_MEM_memRead_out  in  1  load instruction
- EX_MEM_memWrite_out  in  1  store instruction
- EX_MEM_memToReg_out  in  1  write-back selects memory data
- EX_MEM_regWrite_out  in  1  instruction writes register file
- EX_MEM_size_out  in  2  00 byte, 01 halfword, 10/11 word
- EX_MEM_unsigned_out  in  1  1 = zero-extend load (lbu/lhu), 0 = sign-extend
- MEM_WB_readData_out  out  32  extended load data
- MEM_WB_aluResult_out  out  32  registered ALU result
- MEM_WB_rd_out  out  5  registered destination register
- MEM_WB_regWrite_out  out  1  registered write enable (forced 0 on misaligned load)
- MEM_WB_memToReg_out  out  1  registered mux select
- MEM_WB_misaligned_out  out  1  pulse: the instruction in MEM/WB was a misaligned access

## Operation
- Memory: 2^ADDR_WIDTH x 32-bit words; word index = aluResult[ADDR_WIDTH+1:2]; higher address bits ignored (address wraps modulo depth). Contents not affected by RST.
- Byte lanes big-endian: offset 0 = bits [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0]; halfword offset 0 = [31:16], 2 = [15:0].
- Misaligned: halfword with addr[0]=1, word with addr[1:0]!=00; byte never misaligned. Evaluated only when memRead or memWrite is 1.
- Store (memWrite=1, aligned, STALL=0, RST=0): only the addressed lanes written; byte stores writeData[7:0], halfword stores writeData[15:0]; other lanes of the word unchanged.
- Misaligned store: memory unchanged; misaligned flag set in MEM/WB.
- Load: read word combinationally from array, select lane(s), extend per unsigned bit; result registered into MEM_WB_readData_out.
- Misaligned load: MEM_WB_readData_out = 0, MEM_WB_regWrite_out = 0, flag = 1.
- Non-memory instruction: MEM_WB_readData_out = 0; all other fields pass through.
- memRead and memWrite both 1: treated as store; readData = 0.
- STALL=1: all MEM/WB outputs hold previous value; no store performed.
- RST priority over STALL and over any store in the same cycle.

## Timing
- Reset: every MEM/WB output = 0 on the first rising edge with RST=1; remains 0 while RST held.
- Latency: EX/MEM values present before edge N appear on MEM/WB outputs after edge N (1 cycle).
- Store committed at edge N; load presented in cycle after edge N to the same word returns new data (no bypass needed).
- MEM_WB_misaligned_out is 1 for exactly the cycle(s) the offending instruction occupies MEM/WB (held during STALL).
- No combinational path from any input to any output.

## Test plan
- Reset: drive RST=1 for 2 cycles with memWrite=1, addr 0x0, data 0xFFFFFFFF -> all outputs 0; later lw 0x0 after writing 0x0 with sw 0x12345678 returns 0x12345678 (reset store suppressed).
- Word store/load: sw 0xDEADBEEF @0x10, next cycle lw @0x10 with regWrite=1, rd=8 -> readData 0xDEADBEEF, rd 8, regWrite 1 one cycle later.
- Byte/half extension: after sw 0x80F17F00 @0x20: lb @0x20 -> 0xFFFFFF80, lbu @0x20 -> 0x00000080, lb @0x22 -> 0x0000007F, lh @0x22 -> 0x00007F00, lhu @0x20 -> 0x000080F1.
- Partial store: sw 0x11223344 @0x30, sb 0xAA @0x31, sh 0xBBCC @0x32 -> lw @0x30 = 0x11AABBCC.
- Misaligned: lw @0x41 with regWrite=1 -> readData 0, regWrite 0, misaligned 1; sh 0xFFFF @0x43 -> word 0x40 unchanged, misaligned 1.
- Stall and wrap: STALL=1 with sw 0x5 @0x50 -> MEM/WB outputs unchanged, lw @0x50 afterwards returns prior value; with ADDR_WIDTH=8, sw 0x77 @0x400 then lw @0x0 -> 0x00000077.
